// File: rtl/exp_ascii_fmt.sv
// exp_ascii_fmt
// Formats a signed exponent (ASCII sign + 8-bit magnitude) as an ASCII
// character stream such as "E+127". The magnitude is converted to BCD with
// an 8-cycle shift-add-3 loop, then streamed one character per handshake.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    exponent input handshake
//   exp_sign             ASCII sign character, passed through untouched
//   exp_mag              unsigned magnitude 0..255
//   out_valid/out_ready  character output handshake
//   out_char             ASCII character
//   out_last             marks the units digit, the final character
module exp_ascii_fmt #(
  parameter logic [7:0] PREFIX_CHAR    = 8'h45,
  parameter bit         SUPPRESS_ZEROS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] exp_sign,
  input  logic [7:0] exp_mag,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       out_last
);

  // state | meaning
  // IDLE  | waiting for an exponent
  // CONV  | 8 shift-add-3 iterations on {bcd, mag}
  // EMIT  | streaming prefix, sign and digits
  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;
  typedef enum logic [2:0] {
    IDX_PREFIX, IDX_SIGN, IDX_HUND, IDX_TENS, IDX_UNITS
  } idx_t;

  state_t      state, state_d;
  idx_t        idx_q, idx_next;
  logic [7:0]  sign_q;
  logic [7:0]  mag_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;
  logic [3:0]  cnt_q;
  logic [3:0]  hund, tens, units;

  assign hund  = bcd_q[11:8];
  assign tens  = bcd_q[7:4];
  assign units = bcd_q[3:0];

  // Pre-shift correction: any nibble >= 5 would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Suppressed leading zeros are skipped directly from the sign character,
  // so they cost no cycles. Once a digit is emitted, later zeros are kept.
  always_comb begin
    idx_next = IDX_PREFIX;
    case (idx_q)
      IDX_PREFIX: idx_next = IDX_SIGN;
      IDX_SIGN: begin
        if (SUPPRESS_ZEROS && hund == 4'd0)
          idx_next = (tens == 4'd0) ? IDX_UNITS : IDX_TENS;
        else
          idx_next = IDX_HUND;
      end
      IDX_HUND:  idx_next = IDX_TENS;
      IDX_TENS:  idx_next = IDX_UNITS;
      default:   idx_next = IDX_PREFIX;
    endcase
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        if (cnt_q == 4'd1) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        case (idx_q)
          IDX_PREFIX: out_char = PREFIX_CHAR;
          IDX_SIGN:   out_char = sign_q;
          IDX_HUND:   out_char = {4'h3, hund};
          IDX_TENS:   out_char = {4'h3, tens};
          default: begin
            out_char = {4'h3, units};
            out_last = 1'b1;
          end
        endcase
        if (out_ready && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx_q  <= IDX_PREFIX;
      sign_q <= 8'h00;
      mag_q  <= 8'h00;
      bcd_q  <= 12'h000;
      cnt_q  <= 4'd0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= exp_sign;
            mag_q  <= exp_mag;
            bcd_q  <= 12'h000;
            cnt_q  <= 4'd8;
          end
        end
        CONV: begin
          bcd_q <= {bcd_adj[10:0], mag_q[7]};
          mag_q <= {mag_q[6:0], 1'b0};
          cnt_q <= cnt_q - 4'd1;
          idx_q <= IDX_PREFIX;
        end
        EMIT: begin
          if (out_ready) idx_q <= idx_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_ascii_fmt.sv
// Testbench for exp_ascii_fmt: scoreboard queues filled by the drivers from
// a decimal-arithmetic reference model, drained by negedge monitors.
module tb_exp_ascii_fmt;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0] exp_sign, exp_mag, out_char;

  logic       z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_out_last;
  logic [7:0] z_sign, z_mag, z_out_char;

  always #5 clk = ~clk;

  exp_ascii_fmt #(.PREFIX_CHAR(8'h45), .SUPPRESS_ZEROS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_sign(exp_sign), .exp_mag(exp_mag), .out_valid(out_valid),
    .out_ready(out_ready), .out_char(out_char), .out_last(out_last)
  );

  exp_ascii_fmt #(.PREFIX_CHAR(8'h45), .SUPPRESS_ZEROS(1'b0)) dut_z (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .exp_sign(z_sign), .exp_mag(z_mag), .out_valid(z_out_valid),
    .out_ready(z_out_ready), .out_char(z_out_char), .out_last(z_out_last)
  );

  typedef struct {
    logic [7:0] ch;
    logic       last;
    logic       first;
    int         acc;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  exp_t q[$];
  exp_t zq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rmode = 0;
  int   pidx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: the exponent field written out in decimal.
  function automatic bq_t model(input logic [7:0] s, input int m, input bit sup);
    bq_t r;
    int h, t, u;
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    r.push_back(8'h45);
    r.push_back(s);
    if (!sup || h != 0) r.push_back(8'(8'h30 + h));
    if (!sup || h != 0 || t != 0) r.push_back(8'(8'h30 + t));
    r.push_back(8'(8'h30 + u));
    return r;
  endfunction

  // out_ready pattern: 0 = always 1, 1 = 1,0,0 repeating, 2 = random, 3 = manual
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: begin out_ready = (pidx % 3 == 0); pidx++; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Main monitor
  logic       held = 1'b0;
  logic [7:0] held_ch;
  logic       held_last;
  logic       exp_idle = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 1'b0;
      exp_idle = 1'b0;
    end else begin
      if (exp_idle) begin
        check("in_ready_after_last", in_ready, 1);
        check("out_valid_after_last", out_valid, 0);
        exp_idle = 1'b0;
      end
      if (held) begin
        check("stall_valid", out_valid, 1);
        check("stall_char", out_char, held_ch);
        check("stall_last", out_last, held_last);
      end
      if (out_valid && !held && q.size() > 0 && q[0].first)
        check("first_char_latency", cyc - q[0].acc, 9);
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) fail_now("unexpected_char");
          else begin
            exp_t e;
            e = q.pop_front();
            check("char", out_char, e.ch);
            check("last", out_last, e.last);
            check("busy_in_ready", in_ready, 0);
            if (e.last) exp_idle = 1'b1;
          end
        end else begin
          held = 1'b1;
          held_ch = out_char;
          held_last = out_last;
        end
      end
    end
  end

  // Monitor for the no-suppression instance (out_ready always high)
  always @(negedge clk) begin
    if (rst) zq.delete();
    else if (z_out_valid && z_out_ready) begin
      if (zq.size() == 0) fail_now("z_unexpected_char");
      else begin
        exp_t e;
        e = zq.pop_front();
        check("z_char", z_out_char, e.ch);
        check("z_last", z_out_last, e.last);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [7:0] s, input logic [7:0] m);
    bq_t  chars;
    int   n = 0;
    exp_t e;
    in_valid = 1'b1;
    exp_sign = s;
    exp_mag  = m;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("send_timeout");
    chars = model(s, int'(m), 1'b1);
    foreach (chars[i]) begin
      e.ch = chars[i];
      e.last = (i == chars.size() - 1);
      e.first = (i == 0);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_sign = 8'($urandom);
    exp_mag  = 8'($urandom);
  endtask

  task automatic send_z(input logic [7:0] s, input logic [7:0] m);
    bq_t  chars;
    int   n = 0;
    exp_t e;
    z_in_valid = 1'b1;
    z_sign = s;
    z_mag  = m;
    @(negedge clk);
    while (!z_in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("send_z_timeout");
    chars = model(s, int'(m), 1'b0);
    foreach (chars[i]) begin
      e.ch = chars[i];
      e.last = (i == chars.size() - 1);
      e.first = (i == 0);
      e.acc = cyc;
      zq.push_back(e);
    end
    @(posedge clk);
    #1;
    z_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(q.size() == 0 && zq.size() == 0 && in_ready && z_in_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) fail_now("wait_idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    exp_sign = 8'h00;
    exp_mag = 8'h00;
    out_ready = 1'b1;
    z_in_valid = 1'b0;
    z_sign = 8'h00;
    z_mag = 8'h00;
    z_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_char", out_char, 8'h00);
    check("reset_out_last", out_last, 0);

    rmode = 0;
    send(8'h2B, 8'd127); wait_idle();
    send(8'h2D, 8'd0);   wait_idle();
    send(8'h2B, 8'd5);   wait_idle();
    send(8'h2B, 8'd100); wait_idle();
    send_z(8'h2D, 8'd0);
    send_z(8'h2B, 8'd7);
    send_z(8'h2B, 8'd255);
    wait_idle();

    // Stalls with 1,0,0 ready pattern
    rmode = 1;
    send(8'h2B, 8'd255); wait_idle();

    // Busy input ignored through CONV and into EMIT
    rmode = 0;
    send(8'h2B, 8'd255);
    exp_mag = 8'd9;
    exp_sign = 8'h2D;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("busy_pulse_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset while the tens digit is presented
    rmode = 3;
    out_ready = 1'b1;
    send(8'h2B, 8'd123);
    begin
      int n = 0;
      while (!(out_valid && out_char == 8'h32) && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 40) fail_now("tens_wait_timeout");
    end
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_last", out_last, 0);
    out_ready = 1'b1;
    rmode = 0;
    send(8'h2B, 8'd42); wait_idle();

    // Back-to-back randomized traffic with random backpressure
    rmode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] s, m;
      case ($urandom_range(0, 2))
        0: s = 8'h2B;
        1: s = 8'h2D;
        default: s = 8'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: m = 8'd0;
        1: m = 8'd255;
        2: m = 8'($urandom_range(0, 9));
        default: m = 8'($urandom);
      endcase
      send(s, m);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
